// File: rtl/my_fifo_gen2_pkg.sv
// my_fifo_pkg: shared constants and helpers for the my_fifo_gen2 FIFO.
//   FIFO_STD / FIFO_FWFT : values for the FWFT read-mode parameter
//   addr_w()             : pointer width for a given DEPTH
//   cnt_default_t        : occupancy type for the default DEPTH; a module
//                          with another DEPTH declares its own cnt_t the
//                          same way, as logic [addr_w(DEPTH):0]
package my_fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  localparam int DEFAULT_DEPTH = 1024;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [addr_w(DEFAULT_DEPTH):0] cnt_default_t;

endpackage

// File: rtl/my_fifo_gen2_if.sv
// my_fifo_gen2_if: write, read, threshold and status signals of the FIFO.
// Signal names keep the FIFO-side direction prefixes (i_ = into the FIFO,
// o_ = out of the FIFO).
//   slave  : FIFO side (receives i_*, drives o_*)
//   master : user side (drives i_*, receives o_*)
// Parameters: DATA_W (word width), DEPTH (entries, power of two).
interface my_fifo_gen2_if
  import my_fifo_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 1024
);

  localparam int CW = addr_w(DEPTH) + 1;

  logic              i_wren;
  logic [DATA_W-1:0] i_wrdata;
  logic              o_full;
  logic              o_alm_full;
  logic              i_rden;
  logic [DATA_W-1:0] o_rddata;
  logic              o_rdvalid;
  logic              o_empty;
  logic              o_alm_empty;
  logic              i_th_wr;
  logic [CW-1:0]     i_upp_th;
  logic [CW-1:0]     i_low_th;
  logic [CW-1:0]     o_count;

  modport slave (
    input  i_wren, i_wrdata, i_rden, i_th_wr, i_upp_th, i_low_th,
    output o_full, o_alm_full, o_rddata, o_rdvalid, o_empty, o_alm_empty,
           o_count
  );

  modport master (
    output i_wren, i_wrdata, i_rden, i_th_wr, i_upp_th, i_low_th,
    input  o_full, o_alm_full, o_rddata, o_rdvalid, o_empty, o_alm_empty,
           o_count
  );

endinterface

// File: rtl/my_fifo_gen2_ram.sv
// my_fifo_ram: DEPTH x DATA_W simple dual-port storage for my_fifo_gen2.
// Synchronous write, asynchronous read; contents are never reset.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   AW  write address
//   wr_data  in   DATA_W write word
//   rd_addr  in   AW  read address
//   rd_data  out  DATA_W word at rd_addr (combinational)
module my_fifo_ram
  import my_fifo_pkg::*;
#(
  parameter  int DATA_W = 128,
  parameter  int DEPTH  = 1024,
  localparam int AW     = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/my_fifo_gen2.sv
// my_fifo_gen2: synchronous FIFO with registered full/empty, programmable
// almost-full / almost-empty thresholds and a selectable read mode.
// Parameters:
//   DATA_W     word width (1..1024)
//   DEPTH      entries, power of two, >= 4
//   FWFT       FIFO_STD: registered read data, o_rdvalid one cycle after pop
//              FIFO_FWFT: head entry visible whenever not empty
//   UPP_TH_RST / LOW_TH_RST  reset values of the threshold registers
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        my_fifo_gen2_if.slave (write/read/threshold/status signals)
// Optional feature, macro MY_FIFO_ERR_FLAGS_EN:
//   i_err_clr  in   clears both sticky error flags (a coinciding set wins)
//   o_ovf      out  sticky: a write was dropped because the FIFO was full
//   o_udf      out  sticky: a read was dropped because the FIFO was empty
module my_fifo_gen2
  import my_fifo_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int DEPTH      = 1024,
  parameter int FWFT       = FIFO_STD,
  parameter int UPP_TH_RST = 4,
  parameter int LOW_TH_RST = 2
) (
  input  logic clk,
  input  logic rst,
`ifdef MY_FIFO_ERR_FLAGS_EN
  input  logic i_err_clr,
  output logic o_ovf,
  output logic o_udf,
`endif
  my_fifo_gen2_if.slave bus
);

  localparam int AW = addr_w(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  function automatic cnt_t clamp_th(input cnt_t v);
    return (v > DEPTH_C) ? DEPTH_C : v;
  endfunction

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  cnt_t              count;
  cnt_t              count_nxt;
  logic              full;
  logic              empty;
  cnt_t              upp_th;
  cnt_t              low_th;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] ram_rd;

  // Requests arriving during reset are ignored, including the RAM write.
  assign wr_acc = bus.i_wren & ~full  & ~rst;
  assign rd_acc = bus.i_rden & ~empty & ~rst;

  my_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (bus.i_wrdata),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd)
  );

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Pointer / occupancy stage: flags are registered from the next count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upp_th <= clamp_th(cnt_t'(UPP_TH_RST));
      low_th <= clamp_th(cnt_t'(LOW_TH_RST));
    end else if (bus.i_th_wr) begin
      upp_th <= clamp_th(bus.i_upp_th);
      low_th <= clamp_th(bus.i_low_th);
    end
  end

  // upp_th never exceeds DEPTH, so the subtraction cannot wrap.
  assign bus.o_alm_full  = (count >= (DEPTH_C - upp_th));
  assign bus.o_alm_empty = (count <= low_th);
  assign bus.o_full      = full;
  assign bus.o_empty     = empty;
  assign bus.o_count     = count;

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      // Head entry is read straight from the RAM; forced to zero while empty
      // so the output is defined during and right after reset.
      assign bus.o_rddata  = empty ? '0 : ram_rd;
      assign bus.o_rdvalid = ~empty;
    end else begin : g_std
      logic [DATA_W-1:0] rd_data_p1;
      logic              vld_p1;

      // Read output stage: one register between pop and data.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_p1 <= '0;
          vld_p1     <= 1'b0;
        end else begin
          vld_p1 <= rd_acc;
          if (rd_acc) rd_data_p1 <= ram_rd;
        end
      end

      assign bus.o_rddata  = rd_data_p1;
      assign bus.o_rdvalid = vld_p1;
    end
  endgenerate

`ifdef MY_FIFO_ERR_FLAGS_EN
  logic wr_drop;
  logic rd_drop;
  logic ovf;
  logic udf;

  assign wr_drop = bus.i_wren & full;
  assign rd_drop = bus.i_rden & empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_drop)        ovf <= 1'b1;
      else if (i_err_clr) ovf <= 1'b0;
      if (rd_drop)        udf <= 1'b1;
      else if (i_err_clr) udf <= 1'b0;
    end
  end

  assign o_ovf = ovf;
  assign o_udf = udf;
`endif

endmodule

// File: tb/tb_my_fifo_gen2.sv
// tb_my_fifo_gen2: directed bench for my_fifo_gen2 with DEPTH=8, DATA_W=8.
// A standard-mode and an FWFT-mode instance share one stimulus stream; a
// queue-based model predicts both every cycle, and directed steps pin the
// model with hand-computed values. Honours MY_FIFO_ERR_FLAGS_EN.
module tb_my_fifo_gen2;
  import my_fifo_pkg::*;

  localparam int DW = 8;
  localparam int DP = 8;

  logic       clk;
  logic       rst;
  logic       wren;
  logic [7:0] wrdata;
  logic       rden;
  logic       th_wr;
  logic [3:0] upp;
  logic [3:0] low;
  logic       err_clr;
  logic       chk_en;

  int checks = 0;
  int errors = 0;

  my_fifo_gen2_if #(.DATA_W(DW), .DEPTH(DP)) bs ();
  my_fifo_gen2_if #(.DATA_W(DW), .DEPTH(DP)) bf ();

  assign bs.i_wren = wren;   assign bf.i_wren = wren;
  assign bs.i_wrdata = wrdata; assign bf.i_wrdata = wrdata;
  assign bs.i_rden = rden;   assign bf.i_rden = rden;
  assign bs.i_th_wr = th_wr; assign bf.i_th_wr = th_wr;
  assign bs.i_upp_th = upp;  assign bf.i_upp_th = upp;
  assign bs.i_low_th = low;  assign bf.i_low_th = low;

`ifdef MY_FIFO_ERR_FLAGS_EN
  logic ovf_s, udf_s, ovf_f, udf_f;
`endif

  my_fifo_gen2 #(.DATA_W(DW), .DEPTH(DP), .FWFT(FIFO_STD)) dut_std (
    .clk       (clk),
    .rst       (rst),
`ifdef MY_FIFO_ERR_FLAGS_EN
    .i_err_clr (err_clr),
    .o_ovf     (ovf_s),
    .o_udf     (udf_s),
`endif
    .bus       (bs.slave)
  );

  my_fifo_gen2 #(.DATA_W(DW), .DEPTH(DP), .FWFT(FIFO_FWFT)) dut_fw (
    .clk       (clk),
    .rst       (rst),
`ifdef MY_FIFO_ERR_FLAGS_EN
    .i_err_clr (err_clr),
    .o_ovf     (ovf_f),
    .o_udf     (udf_f),
`endif
    .bus       (bf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: occupancy is the queue, thresholds are plain ints.
  logic [7:0] q[$];
  int         m_upp, m_low, sz, n;
  logic [7:0] m_sdata;
  logic       m_svld, m_ovf, m_udf, wr_ok, rd_ok;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_upp = 4; m_low = 2;
      m_sdata = 8'h00; m_svld = 1'b0;
      m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      sz    = q.size();
      wr_ok = wren && (sz < DP);
      rd_ok = rden && (sz > 0);
      m_svld = rd_ok;
      if (rd_ok) m_sdata = q.pop_front();
      if (wr_ok) q.push_back(wrdata);
      if (th_wr) begin
        m_upp = (int'(upp) > DP) ? DP : int'(upp);
        m_low = (int'(low) > DP) ? DP : int'(low);
      end
      if (wren && sz == DP) m_ovf = 1'b1; else if (err_clr) m_ovf = 1'b0;
      if (rden && sz == 0)  m_udf = 1'b1; else if (err_clr) m_udf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n = q.size();
      chk("std_count", 32'(bs.o_count), n);
      chk("fw_count", 32'(bf.o_count), n);
      chk("std_full", 32'(bs.o_full), (n == DP));
      chk("fw_full", 32'(bf.o_full), (n == DP));
      chk("std_empty", 32'(bs.o_empty), (n == 0));
      chk("fw_empty", 32'(bf.o_empty), (n == 0));
      chk("std_alm_full", 32'(bs.o_alm_full), (n >= DP - m_upp));
      chk("fw_alm_full", 32'(bf.o_alm_full), (n >= DP - m_upp));
      chk("std_alm_empty", 32'(bs.o_alm_empty), (n <= m_low));
      chk("fw_alm_empty", 32'(bf.o_alm_empty), (n <= m_low));
      chk("std_rdvalid", 32'(bs.o_rdvalid), 32'(m_svld));
      chk("std_rddata", 32'(bs.o_rddata), 32'(m_sdata));
      chk("fw_rdvalid", 32'(bf.o_rdvalid), (n > 0));
      if (n > 0) chk("fw_rddata", 32'(bf.o_rddata), 32'(q[0]));
`ifdef MY_FIFO_ERR_FLAGS_EN
      chk("std_ovf", 32'(ovf_s), 32'(m_ovf));
      chk("std_udf", 32'(udf_s), 32'(m_udf));
      chk("fw_ovf", 32'(ovf_f), 32'(m_ovf));
      chk("fw_udf", 32'(udf_f), 32'(m_udf));
`endif
    end
  end

  // Apply one cycle of requests, return on the following negedge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    wren = w; wrdata = d; rden = r;
    @(negedge clk);
    wren = 1'b0; rden = 1'b0; th_wr = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wren = 1'b0; wrdata = 8'h00; rden = 1'b0;
    th_wr = 1'b0; upp = '0; low = '0; err_clr = 1'b0; chk_en = 1'b0;

    // Reset state
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_count", 32'(bs.o_count), 0);
    chk("rst_empty", 32'(bs.o_empty), 1);
    chk("rst_full", 32'(bf.o_full), 0);
    chk("rst_std_vld", 32'(bs.o_rdvalid), 0);
    chk("rst_std_data", 32'(bs.o_rddata), 0);
    chk("rst_fw_data", 32'(bf.o_rddata), 0);
    rst = 1'b0;

    // Fill 0..7; alm_full (upp=4) asserts from count 4
    for (int i = 0; i < DP; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (i == 2) chk("alm_full_at3", 32'(bs.o_alm_full), 0);
      if (i == 3) chk("alm_full_at4", 32'(bs.o_alm_full), 1);
    end
    chk("fill_count", 32'(bs.o_count), 8);
    chk("fill_full", 32'(bf.o_full), 1);
    cyc(1'b1, 8'hEE, 1'b0);
    chk("drop_wr_count", 32'(bs.o_count), 8);
`ifdef MY_FIFO_ERR_FLAGS_EN
    chk("ovf_set", 32'(ovf_s), 1);
`endif

    // Drain: std data one cycle after the pop, FWFT shows head beforehand
    for (int i = 0; i < DP; i++) begin
      chk("fw_head", 32'(bf.o_rddata), i);
      cyc(1'b0, 8'h00, 1'b1);
      chk("drain_vld", 32'(bs.o_rdvalid), 1);
      chk("drain_data", 32'(bs.o_rddata), i);
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk("vld_pulse", 32'(bs.o_rdvalid), 0);
    chk("data_hold", 32'(bs.o_rddata), 7);
    chk("drain_empty", 32'(bs.o_empty), 1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("drop_rd_count", 32'(bs.o_count), 0);
    chk("drop_rd_vld", 32'(bs.o_rdvalid), 0);
`ifdef MY_FIFO_ERR_FLAGS_EN
    chk("udf_set", 32'(udf_s), 1);
    err_clr = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);
    chk("clr_ovf", 32'(ovf_s), 0);
    chk("set_wins_udf", 32'(udf_s), 1);
    err_clr = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    chk("clr_udf", 32'(udf_s), 0);
`endif

    // FWFT: word falls through one cycle after the write
    cyc(1'b1, 8'hA5, 1'b0);
    chk("fwft_data", 32'(bf.o_rddata), 32'h A5);
    chk("fwft_vld", 32'(bf.o_rdvalid), 1);
    chk("fwft_std_novld", 32'(bs.o_rdvalid), 0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("fwft_pop_empty", 32'(bf.o_empty), 1);
    chk("fwft_pop_vld", 32'(bf.o_rdvalid), 0);
    chk("std_pop_data", 32'(bs.o_rddata), 32'h A5);

    // Simultaneous read+write at count 0, 3 and 8
    cyc(1'b1, 8'h11, 1'b1);
    chk("simul_0", 32'(bs.o_count), 1);
    cyc(1'b1, 8'h12, 1'b0);
    cyc(1'b1, 8'h13, 1'b0);
    cyc(1'b1, 8'h14, 1'b1);
    chk("simul_3", 32'(bs.o_count), 3);
    chk("simul_3_data", 32'(bs.o_rddata), 32'h11);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
    chk("full_again", 32'(bf.o_count), 8);
    cyc(1'b1, 8'h77, 1'b1);
    chk("simul_8", 32'(bs.o_count), 7);
    chk("simul_8_full", 32'(bs.o_full), 0);

    // Threshold update at count 2
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h02, 1'b0);
    chk("th_def_alm_empty", 32'(bs.o_alm_empty), 1);
    chk("th_def_alm_full", 32'(bs.o_alm_full), 0);
    th_wr = 1'b1; upp = 4'd6; low = 4'd1;
    cyc(1'b0, 8'h00, 1'b0);
    chk("th_alm_empty", 32'(bs.o_alm_empty), 0);
    chk("th_alm_full", 32'(bf.o_alm_full), 1);
    // 15 is the largest 4-bit value above DEPTH; clamps to 8 so alm_full=1
    // (unclamped, 8-15 wraps to 9 and alm_full would be 0)
    th_wr = 1'b1; upp = 4'd15; low = 4'd12;
    cyc(1'b0, 8'h00, 1'b0);
    chk("clamp_alm_full", 32'(bs.o_alm_full), 1);
    chk("clamp_alm_empty", 32'(bs.o_alm_empty), 1);
    th_wr = 1'b1; upp = 4'd4; low = 4'd2;
    cyc(1'b0, 8'h00, 1'b0);
    chk("th_restore", 32'(bs.o_alm_full), 0);

    // Wrap: 20 interleaved cycles, pointers pass the end of the array
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'(8'h30 + i), (i % 3) != 0);
    chk("wrap_count", 32'(bs.o_count), 7);
    chk("wrap_head", 32'(bf.o_rddata), 32'h 3D);

    // Reset mid-stream with requests present in the reset cycle
    rst = 1'b1;
    cyc(1'b1, 8'h55, 1'b1);
    chk("mid_rst_count", 32'(bs.o_count), 0);
    chk("mid_rst_empty", 32'(bf.o_empty), 1);
    chk("mid_rst_vld", 32'(bs.o_rdvalid), 0);
    rst = 1'b0;
    cyc(1'b1, 8'h66, 1'b0);
    chk("post_rst_count", 32'(bs.o_count), 1);
    chk("post_rst_fw", 32'(bf.o_rddata), 32'h66);
    cyc(1'b0, 8'h00, 1'b1);
    chk("post_rst_std", 32'(bs.o_rddata), 32'h66);

    cyc(1'b0, 8'h00, 1'b0);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
